// File: rtl/microc_pkg.sv
// Shared definitions for the microc sequencing control: opcodes, ALU codes,
// run-control states and the control word passed from decoder to FSM.
package microc_pkg;

    localparam logic [5:0] OP_NOP  = 6'b000000;
    localparam logic [5:0] OP_LI   = 6'b000100;  // matches 0001xx
    localparam logic [5:0] OP_J    = 6'b010000;
    localparam logic [5:0] OP_JZ   = 6'b010001;
    localparam logic [5:0] OP_JNZ  = 6'b010010;
    localparam logic [5:0] OP_JR   = 6'b010011;
    localparam logic [5:0] OP_IN   = 6'b011000;
    localparam logic [5:0] OP_HALT = 6'b011111;

    typedef logic [2:0] alu_op_t;

    localparam alu_op_t ALU_ADD = 3'b000;
    localparam alu_op_t ALU_SUB = 3'b001;
    localparam alu_op_t ALU_AND = 3'b010;
    localparam alu_op_t ALU_OR  = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RUN    = 2'd1,
        S_IOWAIT = 2'd2,
        S_HALT   = 2'd3
    } state_t;

    typedef struct packed {
        logic    s_inc;
        logic    s_abs;
        logic    s_inm;
        logic    s_io;
        logic    we3;
        logic    wez;
        alu_op_t op;
        logic    pc_en;
        logic    io_req;
    } ctrl_t;

    localparam ctrl_t CTRL_OFF = '0;

endpackage

// File: rtl/microc_decoder.sv
// Pure combinational instruction decode: opcode and Z flag to a control word,
// plus flags telling the run-control FSM that an IN or HALT was seen.
module microc_decoder
    import microc_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic       z,
    output ctrl_t      ctrl,
    output logic       is_in,
    output logic       is_halt
);

    always_comb begin
        // NOTE: every output gets a default before any branch, so no path can infer a latch.
        ctrl    = CTRL_OFF;
        is_in   = 1'b0;
        is_halt = 1'b0;

        if (opcode[5]) begin
            ctrl.op    = opcode[4:2];
            ctrl.we3   = 1'b1;
            ctrl.wez   = 1'b1;
            ctrl.s_inc = 1'b1;
            ctrl.pc_en = 1'b1;
        end else if (opcode[5:2] == OP_LI[5:2]) begin
            ctrl.s_inm = 1'b1;
            ctrl.we3   = 1'b1;
            ctrl.s_inc = 1'b1;
            ctrl.pc_en = 1'b1;
        end else begin
            case (opcode)
                OP_J: begin
                    ctrl.s_abs = 1'b1;
                    ctrl.pc_en = 1'b1;
                end
                OP_JZ: begin
                    ctrl.s_abs = z;
                    ctrl.s_inc = ~z;
                    ctrl.pc_en = 1'b1;
                end
                OP_JNZ: begin
                    ctrl.s_abs = ~z;
                    ctrl.s_inc = z;
                    ctrl.pc_en = 1'b1;
                end
                OP_JR: begin
                    ctrl.pc_en = 1'b1;
                end
                OP_IN: begin
                    ctrl.io_req = 1'b1;
                    is_in       = 1'b1;
                end
                OP_HALT: begin
                    is_halt = 1'b1;
                end
                // NOP and every illegal opcode just step the PC
                default: begin
                    ctrl.s_inc = 1'b1;
                    ctrl.pc_en = 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/microc_ctrl.sv
// Run-control FSM for microc: gates the decoded control word by state, handles
// stall, HALT, and the IN req/ack handshake with a bounded wait.
module microc_ctrl
    import microc_pkg::*;
#(
    parameter int IO_TIMEOUT = 16,
    parameter int CNT_W      = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       stall,
    input  logic [5:0] opcode,
    input  logic       z,
    input  logic       io_ack,
    output logic       s_inc,
    output logic       s_abs,
    output logic       s_inm,
    output logic       s_io,
    output logic       we3,
    output logic       wez,
    output logic [2:0] op,
    output logic       pc_en,
    output logic       io_req,
    output logic       halted,
    output logic       io_err
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(IO_TIMEOUT - 1);

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic             io_err_set;
    ctrl_t            dec, ctrl;
    logic             dec_in, dec_halt;

    microc_decoder u_decoder (
        .opcode  (opcode),
        .z       (z),
        .ctrl    (dec),
        .is_in   (dec_in),
        .is_halt (dec_halt)
    );

    // NOTE: state registers use non-blocking assignments; combinational blocks use blocking.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= S_IDLE;
            cnt    <= '0;
            io_err <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            if (io_err_set) io_err <= 1'b1;
        end
    end

    always_comb begin
        ctrl       = CTRL_OFF;
        state_next = state;
        cnt_next   = cnt;
        io_err_set = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) state_next = S_RUN;
            end
            S_RUN: begin
                // a stalled cycle issues nothing, so a stalled IN/HALT is simply retried
                if (!stall) begin
                    ctrl = dec;
                    if (dec_in) begin
                        state_next = S_IOWAIT;
                        cnt_next   = '0;
                    end else if (dec_halt) begin
                        state_next = S_HALT;
                    end
                end
            end
            S_IOWAIT: begin
                ctrl.io_req = 1'b1;
                if (io_ack) begin
                    ctrl.we3   = 1'b1;
                    ctrl.s_io  = 1'b1;
                    ctrl.s_inc = 1'b1;
                    ctrl.pc_en = 1'b1;
                    state_next = S_RUN;
                end else if (cnt == CNT_LAST) begin
                    // abandon the IN: skip past it without writing the register file
                    ctrl.s_inc = 1'b1;
                    ctrl.pc_en = 1'b1;
                    io_err_set = 1'b1;
                    state_next = S_RUN;
                end else begin
                    cnt_next = cnt + 1'b1;
                end
            end
            S_HALT: begin
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign s_inc  = ctrl.s_inc;
    assign s_abs  = ctrl.s_abs;
    assign s_inm  = ctrl.s_inm;
    assign s_io   = ctrl.s_io;
    assign we3    = ctrl.we3;
    assign wez    = ctrl.wez;
    assign op     = ctrl.op;
    assign pc_en  = ctrl.pc_en;
    assign io_req = ctrl.io_req;
    assign halted = (state == S_HALT);

endmodule

// File: tb/tb_microc_ctrl.sv
// Directed bench for microc_ctrl: inputs driven on the falling edge, outputs
// compared 1 ns later against hand-computed control vectors.
module tb_microc_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic       stall = 1'b0;
    logic [5:0] opcode = 6'b000000;
    logic       z = 1'b0;
    logic       io_ack = 1'b0;
    logic       s_inc, s_abs, s_inm, s_io, we3, wez, pc_en, io_req, halted, io_err;
    logic [2:0] op;
    logic [11:0] obs;

    int n_checks = 0;
    int n_errors = 0;

    localparam logic [5:0] NOP = 6'b000000, LI0 = 6'b000100, LI3 = 6'b000111;
    localparam logic [5:0] ADD = 6'b100000, ALU5 = 6'b110100, J = 6'b010000;
    localparam logic [5:0] JZ = 6'b010001, JNZ = 6'b010010, JR = 6'b010011;
    localparam logic [5:0] IN = 6'b011000, HALT = 6'b011111;

    microc_ctrl #(.IO_TIMEOUT(4), .CNT_W(8)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .stall  (stall),
        .opcode (opcode),
        .z      (z),
        .io_ack (io_ack),
        .s_inc  (s_inc),
        .s_abs  (s_abs),
        .s_inm  (s_inm),
        .s_io   (s_io),
        .we3    (we3),
        .wez    (wez),
        .op     (op),
        .pc_en  (pc_en),
        .io_req (io_req),
        .halted (halted),
        .io_err (io_err)
    );

    always #5 clk = ~clk;

    assign obs = {s_inc, s_abs, s_inm, s_io, we3, wez, op, pc_en, io_req, halted};

    // order: s_inc s_abs s_inm s_io we3 wez op pc_en io_req halted
    function automatic logic [11:0] cw(input logic si, sa, sm, sio, w3, wz,
                                       input logic [2:0] o, input logic pe, rq, h);
        return {si, sa, sm, sio, w3, wz, o, pe, rq, h};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs on the falling edge, compare outputs 1 ns later.
    task automatic vec(input string tag, input logic rst_v, st_v, stall_v,
                       input logic [5:0] opc, input logic z_v, ack_v, input logic [11:0] exp);
        @(negedge clk);
        reset  = rst_v;
        start  = st_v;
        stall  = stall_v;
        opcode = opc;
        z      = z_v;
        io_ack = ack_v;
        #1;
        check(tag, {20'b0, obs}, {20'b0, exp});
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] OFF, REQ, STEP, TAKE, LI_W, IN_OK;
        OFF   = cw(0,0,0,0,0,0,3'b000,0,0,0);
        REQ   = cw(0,0,0,0,0,0,3'b000,0,1,0);
        STEP  = cw(1,0,0,0,0,0,3'b000,1,0,0);
        TAKE  = cw(0,1,0,0,0,0,3'b000,1,0,0);
        LI_W  = cw(1,0,1,0,1,0,3'b000,1,0,0);
        IN_OK = cw(1,0,0,1,1,0,3'b000,1,1,0);

        // reset held three cycles, then idle and start
        for (int i = 0; i < 3; i++) vec("reset", 0, 0, 0, NOP, 0, 0, OFF);
        check("io_err_rst", {31'b0, io_err}, 32'd0);
        vec("idle",  1, 0, 0, ADD, 0, 0, OFF);
        vec("start", 1, 1, 0, ADD, 0, 0, OFF);

        // straight-line program and branches
        vec("li0",     1, 0, 0, LI0,  0, 0, LI_W);
        vec("li3",     1, 0, 0, LI3,  0, 0, LI_W);
        vec("add",     1, 0, 0, ADD,  0, 0, cw(1,0,0,0,1,1,3'b000,1,0,0));
        vec("alu5",    1, 0, 0, ALU5, 0, 0, cw(1,0,0,0,1,1,3'b101,1,0,0));
        vec("jnz_z0",  1, 0, 0, JNZ,  0, 0, TAKE);
        vec("jnz_z1",  1, 0, 0, JNZ,  1, 0, STEP);
        vec("jz_z1",   1, 0, 0, JZ,   1, 0, TAKE);
        vec("jz_z0",   1, 0, 0, JZ,   0, 0, STEP);
        vec("j",       1, 0, 0, J,    1, 0, TAKE);
        vec("jr",      1, 0, 0, JR,   0, 0, cw(0,0,0,0,0,0,3'b000,1,0,0));
        vec("nop",     1, 0, 0, NOP,  0, 0, STEP);
        vec("ill_03",  1, 0, 0, 6'b000011, 0, 0, STEP);
        vec("ill_19",  1, 0, 0, 6'b011001, 0, 0, STEP);
        vec("ill_14",  1, 0, 0, 6'b010100, 1, 0, STEP);

        // IN acknowledged on the third wait cycle; opcode and stall ignored while waiting
        vec("in_a",    1, 0, 0, IN,  0, 0, REQ);
        vec("wait_a0", 1, 0, 1, ADD, 0, 0, REQ);
        vec("wait_a1", 1, 0, 1, ADD, 0, 0, REQ);
        vec("ack_a",   1, 0, 1, ADD, 0, 1, IN_OK);
        vec("after_a", 1, 0, 0, NOP, 0, 0, STEP);
        check("io_err_ack", {31'b0, io_err}, 32'd0);

        // IN with no ack: four wait cycles, last one abandons
        vec("in_t",    1, 0, 0, IN,  0, 0, REQ);
        for (int i = 0; i < 3; i++) vec("wait_t", 1, 0, 0, NOP, 0, 0, REQ);
        vec("tmo",     1, 0, 0, NOP, 0, 0, cw(1,0,0,0,0,0,3'b000,1,1,0));
        check("io_err_pre", {31'b0, io_err}, 32'd0);
        vec("after_t", 1, 0, 0, NOP, 0, 0, STEP);
        check("io_err_set", {31'b0, io_err}, 32'd1);

        // ack arriving on the timeout cycle still completes the IN
        vec("in_e",    1, 0, 0, IN,  0, 0, REQ);
        for (int i = 0; i < 3; i++) vec("wait_e", 1, 0, 0, NOP, 0, 0, REQ);
        vec("ack_edge", 1, 0, 0, NOP, 0, 1, IN_OK);
        vec("after_e", 1, 0, 0, NOP, 0, 0, STEP);
        check("io_err_sticky", {31'b0, io_err}, 32'd1);

        // stall beats ALU, HALT and IN; state stays in run
        vec("stall_alu", 1, 0, 1, ADD,  0, 0, OFF);
        vec("alu_rel",   1, 0, 0, ADD,  0, 0, cw(1,0,0,0,1,1,3'b000,1,0,0));
        vec("stall_hlt", 1, 0, 1, HALT, 0, 0, OFF);
        vec("stall_in",  1, 0, 1, IN,   0, 0, OFF);
        vec("still_run", 1, 0, 0, NOP,  0, 0, STEP);
        vec("halt",      1, 0, 0, HALT, 0, 0, OFF);
        vec("halted",    1, 1, 0, ADD,  0, 0, cw(0,0,0,0,0,0,3'b000,0,0,1));
        vec("halt_start",1, 1, 0, IN,   0, 1, cw(0,0,0,0,0,0,3'b000,0,0,1));

        // reset recovers from halt and clears io_err
        vec("rst_halt",  0, 0, 0, NOP,  0, 0, cw(0,0,0,0,0,0,3'b000,0,0,1));
        vec("idle2",     1, 0, 0, ADD,  0, 0, OFF);
        check("io_err_clr", {31'b0, io_err}, 32'd0);
        vec("start2",    1, 1, 0, NOP,  0, 0, OFF);

        // reset in the middle of an IN wait
        vec("in_r",      1, 0, 0, IN,   0, 0, REQ);
        vec("wait_r",    1, 0, 0, NOP,  0, 0, REQ);
        vec("rst_wait",  0, 0, 0, NOP,  0, 0, REQ);
        vec("idle3",     1, 0, 0, NOP,  0, 1, OFF);
        check("io_err_r", {31'b0, io_err}, 32'd0);
        vec("start3",    1, 1, 0, NOP,  0, 0, OFF);

        // wait counter restarts from zero after reset
        vec("in_2",      1, 0, 0, IN,   0, 0, REQ);
        for (int i = 0; i < 3; i++) vec("wait_2", 1, 0, 0, NOP, 0, 0, REQ);
        vec("tmo_2",     1, 0, 0, NOP,  0, 0, cw(1,0,0,0,0,0,3'b000,1,1,0));
        vec("after_2",   1, 0, 0, LI0,  0, 0, LI_W);
        check("io_err_2", {31'b0, io_err}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
